alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter IW, default 3, instruction width in bits; minimum 2.
REQ-002 Parameter HOLD_FIM, default 1, number of cycles fim stays high; minimum 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to run one program; sampled only in IDLE.
REQ-006 instrucao  input  IW  program select; captured on the accepted start.
REQ-007 EnA, EnB, EnC  output  1 each  load enables for registers A, B, C.
REQ-008 Sel_in  output  1  datapath input mux: 0 = external data, 1 = ALU result.
REQ-009 Sel_R  output  1  ALU second-operand mux: 0 = reg B, 1 = reg C.
REQ-010 Op  output  2  ALU op: 00 none, 01 add, 10 sub.
REQ-011 Op_Reg  output  2  reg D op: 00 hold, 01 load, 10 shift right 1, 11 shift left 1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 fim  output  1  completion flag.
REQ-014 err  output  1  illegal-instruction flag; present only when ALU_SEQ_ERR_EN is defined.

Function
REQ-015 Moore FSM; outputs decode from state only; any output not listed for a state is 0.
REQ-016 States: IDLE, LDA, LDB, LDC, STEP (with a 2-bit step counter), DONE (with a hold counter).
REQ-017 IDLE: all outputs 0; start=1 -> LDA and capture instrucao; start=0 -> stay in IDLE.
REQ-018 LDA: EnA=1 -> LDB. LDB: EnB=1 -> LDC. LDC: EnC=1 -> STEP with step=0.
REQ-019 Program 0 (a+2b-c), 4 steps:
- {EnA, Sel_in, Op=01}
- {EnA, Sel_in, Op=01}
- {EnC, Sel_in, Sel_R, Op=10}
- {Sel_in, Sel_R, Op_Reg=01}
REQ-020 Program 1 ((a+b+c)/2), 4 steps:
- {EnA, Sel_in, Op=01}
- {EnC, Sel_in, Sel_R, Op=01}
- {Sel_in, Sel_R, Op_Reg=01}
- {Sel_in, Sel_R, Op_Reg=10}
REQ-021 Program 2 (a-b+c), 3 steps:
- {EnA, Sel_in, Op=10}
- {EnC, Sel_in, Sel_R, Op=01}
- {Sel_in, Sel_R, Op_Reg=01}
REQ-022 Program 3 ((a+b)*2), 3 steps:
- {EnC, Sel_in, Op=01}
- {Sel_in, Sel_R, Op_Reg=01}
- {Sel_in, Sel_R, Op_Reg=11}
REQ-023 STEP leaves for DONE after the last step of the captured program; the step counter advances by 1 per cycle and never wraps.
REQ-024 DONE: fim=1, busy=1 for exactly HOLD_FIM cycles, then -> IDLE.
REQ-025 Latency: start accepted at edge t -> fim first high in cycle t+4+k, where k = program step count (program 0: t+8).
REQ-026 start while busy is ignored; the captured instruction is not altered mid-program.
REQ-027 Codes 4..2^IW-1 are illegal; their handling is defined by REQ-031/REQ-032.

Reset
REQ-028 rst=1 at an edge forces IDLE, clears the step and hold counters, clears the captured instruction, and drives all outputs to 0 from the next cycle.
REQ-029 rst has priority over start; reset during STEP or DONE aborts the program with no fim pulse.
REQ-030 start=1 on the first edge after rst falls is accepted normally.

Configuration
REQ-031 Macro ALU_SEQ_ERR_EN defined:
- An illegal code skips LDA..STEP: IDLE -> DONE.
- DONE asserts err and fim together for HOLD_FIM cycles.
- No enable or Op_Reg output is asserted during that run.
- err is 0 in all other cases.
REQ-032 Macro ALU_SEQ_ERR_EN undefined: err port absent; an illegal code executes program 0.

Verification
REQ-033 IW=3, HOLD_FIM=1, start with instrucao=0 at edge 0 -> EnA cycle 1, EnB 2, EnC 3; steps per REQ-019 in cycles 4-7; fim=1 in cycle 8 only; IDLE in cycle 9.
REQ-034 instrucao=1 -> Op_Reg=01 in cycle 6 and 10 in cycle 7; fim in cycle 8. instrucao=3 -> Op_Reg=11 in cycle 6; fim in cycle 7.
REQ-035 HOLD_FIM=3, instrucao=2 -> fim high in cycles 7-9, busy low in cycle 10.
REQ-036 rst=1 at the edge ending cycle 5 of program 0 -> all outputs 0 from cycle 6; fim never asserts; a new start then runs a full program.
REQ-037 start pulsed every cycle from cycle 1 to cycle 7 during program 0 -> exactly one fim pulse; a second program starts only after IDLE is reached.
REQ-038 instrucao=5: with ALU_SEQ_ERR_EN, err=fim=1 in cycle 1 and no enables assert; without it, outputs match REQ-033.

Source files
------------

// File: rtl/alu_sequencer.sv
// Moore sequencer that drives the A/B/C/D datapath through one of four fixed ALU programs.
// Optional macro ALU_SEQ_ERR_EN adds an err port and routes illegal program codes straight to DONE.
module alu_sequencer #(
  parameter int IW       = 3,
  parameter int HOLD_FIM = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] instrucao,
  output logic          EnA,
  output logic          EnB,
  output logic          EnC,
  output logic          Sel_in,
  output logic          Sel_R,
  output logic [1:0]    Op,
  output logic [1:0]    Op_Reg,
  output logic          busy,
  output logic          fim
`ifdef ALU_SEQ_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int HW = (HOLD_FIM > 1) ? $clog2(HOLD_FIM) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LDA, S_LDB, S_LDC, S_STEP, S_DONE
  } state_t;

  typedef struct packed {
    logic       ena;
    logic       enb;
    logic       enc;
    logic       sel_in;
    logic       sel_r;
    logic [1:0] op;
    logic [1:0] op_reg;
    logic       busy;
    logic       fim;
  } out_t;

  state_t        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    prog_q, prog_d;
  out_t          out_q, out_d;
  logic          legal;
  logic [1:0]    last_step;

  // Outputs are a pure function of state; evaluating this on the next state
  // and registering it keeps the outputs glitch-free and aligned with state_q.
  function automatic out_t decode(state_t s, logic [1:0] st, logic [1:0] p);
    out_t o;
    o = '0;
    o.busy = (s != S_IDLE);
    o.fim  = (s == S_DONE);
    case (s)
      S_LDA: o.ena = 1'b1;
      S_LDB: o.enb = 1'b1;
      S_LDC: o.enc = 1'b1;
      S_STEP: begin
        o.sel_in = 1'b1;
        case ({p, st})
          4'b00_00, 4'b00_01, 4'b01_00: begin o.ena = 1'b1; o.op = 2'b01; end
          4'b00_10: begin o.enc = 1'b1; o.sel_r = 1'b1; o.op = 2'b10; end
          4'b01_01, 4'b10_01: begin o.enc = 1'b1; o.sel_r = 1'b1; o.op = 2'b01; end
          4'b10_00: begin o.ena = 1'b1; o.op = 2'b10; end
          4'b11_00: begin o.enc = 1'b1; o.op = 2'b01; end
          4'b00_11, 4'b01_10, 4'b10_10, 4'b11_01: begin o.sel_r = 1'b1; o.op_reg = 2'b01; end
          4'b01_11: begin o.sel_r = 1'b1; o.op_reg = 2'b10; end
          4'b11_10: begin o.sel_r = 1'b1; o.op_reg = 2'b11; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return o;
  endfunction

  assign legal     = ((instrucao >> 2) == '0);
  // Programs 0 and 1 run four steps, programs 2 and 3 run three.
  assign last_step = prog_q[1] ? 2'd2 : 2'd3;

`ifdef ALU_SEQ_ERR_EN
  logic ill_q, ill_d;
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hold_d  = hold_q;
    prog_d  = prog_q;
`ifdef ALU_SEQ_ERR_EN
    ill_d   = ill_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          step_d = 2'd0;
          hold_d = '0;
          prog_d = legal ? instrucao[1:0] : 2'd0;
`ifdef ALU_SEQ_ERR_EN
          ill_d   = !legal;
          state_d = legal ? S_LDA : S_DONE;
`else
          state_d = S_LDA;
`endif
        end
      end
      S_LDA: state_d = S_LDB;
      S_LDB: state_d = S_LDC;
      S_LDC: begin
        step_d  = 2'd0;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (step_q == last_step) begin
          hold_d  = '0;
          state_d = S_DONE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      S_DONE: begin
        if (hold_q == HOLD_LAST) state_d = S_IDLE;
        else                     hold_d  = hold_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    out_d = decode(state_d, step_d, prog_d);
`ifdef ALU_SEQ_ERR_EN
    err_d = (state_d == S_DONE) && ill_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      hold_q  <= '0;
      prog_q  <= 2'd0;
      out_q   <= '0;
`ifdef ALU_SEQ_ERR_EN
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      prog_q  <= prog_d;
      out_q   <= out_d;
`ifdef ALU_SEQ_ERR_EN
      ill_q   <= ill_d;
      err_q   <= err_d;
`endif
    end
  end

  assign EnA    = out_q.ena;
  assign EnB    = out_q.enb;
  assign EnC    = out_q.enc;
  assign Sel_in = out_q.sel_in;
  assign Sel_R  = out_q.sel_r;
  assign Op     = out_q.op;
  assign Op_Reg = out_q.op_reg;
  assign busy   = out_q.busy;
  assign fim    = out_q.fim;
`ifdef ALU_SEQ_ERR_EN
  assign err    = err_q;
`endif

endmodule
